// File: rtl/priority_scan_encoder.sv
// priority_scan_encoder
//
// Captures a WIDTH-bit request vector over a valid/ready handshake, then emits
// the index of every set bit, one per output beat, in priority order
// (highest index first when MSB_FIRST=1, lowest first otherwise). An all-zero
// vector produces a single beat flagged with out_none.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request vector presented on in_vec
//   in_ready   block is idle and will capture in_vec this cycle
//   in_vec     request vector (sampled only at accept)
//   out_valid  a beat is presented on out_idx/out_last/out_none/out_count
//   out_ready  consumer takes the current beat
//   out_idx    index of the highest-priority pending bit
//   out_last   current beat is the final one for this vector
//   out_none   captured vector was all-zero
//   out_count  number of set bits in the captured vector
`timescale 1ns/1ps

module priority_scan_encoder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic [IDX_W:0]   out_count
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pending_q;
  logic [IDX_W:0]   count_q;
  logic             none_q;

  logic [IDX_W-1:0] idx_s;
  logic [WIDTH-1:0] idx_mask_s;
  logic             single_s;
  logic             last_s;
  logic             fire_s;

  // Priority encode; a zero vector encodes to index 0.
  function automatic logic [IDX_W-1:0] prio_encode(input logic [WIDTH-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (MSB_FIRST) begin
      // Ascending scan: the last hit, i.e. the highest set bit, wins.
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          idx = IDX_W'(i);
        end else begin
          idx = idx;
        end
      end
    end else begin
      // Descending scan: the last hit, i.e. the lowest set bit, wins.
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx = IDX_W'(i);
        end else begin
          idx = idx;
        end
      end
    end
    return idx;
  endfunction

  // Number of set bits; IDX_W+1 bits hold the all-ones count WIDTH.
  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] vec);
    logic [IDX_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{IDX_W{1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  assign idx_s      = prio_encode(pending_q);
  assign idx_mask_s = {{(WIDTH-1){1'b0}}, 1'b1} << idx_s;
  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign single_s   = (pending_q != '0) &&
                      ((pending_q & (pending_q - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);
  // A zero vector is its own final (and only) beat.
  assign last_s     = (state_q == SCAN) && (single_s || none_q);
  assign fire_s     = (state_q == SCAN) && out_ready;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SCAN);
  assign out_idx   = idx_s;
  assign out_last  = last_s;
  assign out_none  = none_q;
  assign out_count = count_q;

  // Handshake FSM: capture in IDLE, retire one index per transfer in SCAN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      none_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            pending_q <= in_vec;
            count_q   <= popcount(in_vec);
            none_q    <= (in_vec == '0);
            state_q   <= SCAN;
          end else begin
            state_q   <= IDLE;
          end
        end
        SCAN: begin
          if (fire_s && last_s) begin
            pending_q <= '0;
            count_q   <= '0;
            none_q    <= 1'b0;
            state_q   <= IDLE;
          end else if (fire_s) begin
            pending_q <= pending_q & ~idx_mask_s;
          end else begin
            state_q   <= SCAN;
          end
        end
        default: begin
          state_q   <= IDLE;
          pending_q <= '0;
          count_q   <= '0;
          none_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// tb_priority_scan_encoder
//
// Drives two encoder instances (WIDTH=8 MSB-first, WIDTH=16 LSB-first) and
// compares every presented beat against a scoreboard queue of beats computed
// from the driven vector.
`timescale 1ns/1ps

module tb_priority_scan_encoder;

  logic clk = 1'b0;
  logic rst_n;

  // WIDTH=8, MSB_FIRST=1 instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_last8, out_none8;
  logic [7:0] in_vec8;
  logic [2:0] out_idx8;
  logic [3:0] out_count8;

  // WIDTH=16, MSB_FIRST=0 instance
  logic        in_valid16, in_ready16, out_valid16, out_ready16, out_last16, out_none16;
  logic [15:0] in_vec16;
  logic [3:0]  out_idx16;
  logic [4:0]  out_count16;

  typedef struct {
    int idx;
    bit last;
    bit none;
    int count;
  } beat_t;

  typedef struct {
    logic [7:0] vec;
    int         beats;
    int         first_idx;
  } vec_t;

  beat_t q8[$];
  beat_t q16[$];
  vec_t  tbl[$];
  int    n_vec = 0;
  int    n_err = 0;

  priority_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_vec(in_vec8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_idx(out_idx8),
    .out_last(out_last8), .out_none(out_none8), .out_count(out_count8)
  );

  priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_vec(in_vec16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_idx(out_idx16),
    .out_last(out_last16), .out_none(out_none16), .out_count(out_count16)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic check_beat(input string tag, input int idx, input bit last,
                            input bit none, input int cnt, input beat_t e);
    n_vec++;
    if (idx != e.idx || last != e.last || none != e.none || cnt != e.count) begin
      n_err++;
      $display("FAIL %s: got idx=%0d last=%0d none=%0d count=%0d, want idx=%0d last=%0d none=%0d count=%0d",
               tag, idx, last, none, cnt, e.idx, e.last, e.none, e.count);
    end
  endtask

  // Reference model: list the set bits of v in priority order.
  task automatic push_exp(input bit to16, input int w, input bit msb, input logic [15:0] v);
    int    cnt;
    int    rem;
    int    bi;
    beat_t b;
    cnt = 0;
    for (int i = 0; i < w; i++) cnt = cnt + int'(v[i]);
    if (cnt == 0) begin
      b.idx = 0; b.last = 1'b1; b.none = 1'b1; b.count = 0;
      if (to16) q16.push_back(b); else q8.push_back(b);
    end else begin
      rem = cnt;
      for (int j = 0; j < w; j++) begin
        bi = msb ? (w - 1 - j) : j;
        if (v[bi]) begin
          b.idx = bi; b.last = (rem == 1); b.none = 1'b0; b.count = cnt;
          rem--;
          if (to16) q16.push_back(b); else q8.push_back(b);
        end
      end
    end
  endtask

  // Scoreboard for the 8-bit instance: peek every valid beat, pop on transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      check("hs_excl8", int'(in_ready8 & out_valid8), 0);
      if (out_valid8) begin
        if (q8.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL beat8: got unexpected idx=%0d, want no beat", out_idx8);
        end else begin
          check_beat("beat8", int'(out_idx8), out_last8, out_none8, int'(out_count8), q8[0]);
          if (out_ready8) void'(q8.pop_front());
        end
      end
    end
  end

  // Scoreboard for the 16-bit instance.
  always @(negedge clk) begin
    if (rst_n) begin
      check("hs_excl16", int'(in_ready16 & out_valid16), 0);
      if (out_valid16) begin
        if (q16.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL beat16: got unexpected idx=%0d, want no beat", out_idx16);
        end else begin
          check_beat("beat16", int'(out_idx16), out_last16, out_none16, int'(out_count16), q16[0]);
          if (out_ready16) void'(q16.pop_front());
        end
      end
    end
  end

  // Count SCAN cycles (first one already seen) until in_ready8 returns.
  task automatic drain8(input string tag, input int beats);
    int cyc;
    bit ok;
    cyc = 1;
    ok  = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready8) begin
        ok = 1'b1;
        break;
      end
      cyc++;
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL %s_timeout: got in_ready8=0 after 40 cycles, want 1", tag);
    end
    check({tag, "_cycles"}, cyc, beats);
    check({tag, "_drained"}, q8.size(), 0);
  endtask

  // Called at a negedge with dut8 idle; accept happens at the next posedge.
  task automatic send8(input string tag, input logic [7:0] v, input int beats, input int first);
    check({tag, "_ready"}, int'(in_ready8), 1);
    in_valid8 = 1'b1;
    in_vec8   = v;
    push_exp(1'b0, 8, 1'b1, {8'h00, v});
    @(posedge clk); #2;
    in_valid8 = 1'b0;
    in_vec8   = ~v;
    @(negedge clk);
    check({tag, "_valid"}, int'(out_valid8), 1);
    check({tag, "_first"}, int'(out_idx8), first);
    drain8(tag, beats);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat [6];
    vec_t e;

    e.vec = 8'b10101010; e.beats = 4; e.first_idx = 7; tbl.push_back(e);
    for (int i = 0; i < 8; i++) begin
      e.vec = 8'd1 << i; e.beats = 1; e.first_idx = i; tbl.push_back(e);
    end
    e.vec = 8'h00; e.beats = 1; e.first_idx = 0; tbl.push_back(e);
    e.vec = 8'h81; e.beats = 2; e.first_idx = 7; tbl.push_back(e);
    e.vec = 8'h3C; e.beats = 4; e.first_idx = 5; tbl.push_back(e);

    // Reset held for 3 cycles with a vector offered.
    rst_n       = 1'b0;
    in_valid8   = 1'b1;
    in_vec8     = 8'hFF;
    out_ready8  = 1'b1;
    in_valid16  = 1'b0;
    in_vec16    = 16'h0000;
    out_ready16 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_out_valid", int'(out_valid8), 0);
      check("rst_out_count", int'(out_count8), 0);
      check("rst_in_ready", int'(in_ready8), 1);
    end
    push_exp(1'b0, 8, 1'b1, 16'h00FF);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    in_valid8 = 1'b0;
    @(negedge clk);
    check("rst_first_accept", int'(out_valid8), 1);
    drain8("rst_ff", 8);

    // Table-driven vectors with out_ready held high.
    foreach (tbl[k]) begin
      send8($sformatf("vec%0d", k), tbl[k].vec, tbl[k].beats, tbl[k].first_idx);
    end

    // Backpressure: stall pattern, in_vec scrambled during SCAN.
    pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    out_ready8 = 1'b0;
    in_valid8  = 1'b1;
    in_vec8    = 8'b11000001;
    push_exp(1'b0, 8, 1'b1, 16'h00C1);
    @(posedge clk); #2;
    in_valid8 = 1'b0;
    for (int p = 0; p < 6; p++) begin
      out_ready8 = pat[p];
      in_vec8    = 8'($urandom);
      @(posedge clk); #2;
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    check("bp_idle", int'(in_ready8), 1);
    check("bp_drained", q8.size(), 0);

    // WIDTH=16 LSB-first, reset after the second beat.
    in_valid16 = 1'b1;
    in_vec16   = 16'h8101;
    push_exp(1'b1, 16, 1'b0, 16'h8101);
    @(posedge clk); #2;
    in_valid16 = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("w16_rst_valid", int'(out_valid16), 0);
    check("w16_rst_count", int'(out_count16), 0);
    check("w16_beats_before_rst", q16.size(), 1);
    q16.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("w16_no_idx15", int'(out_valid16), 0);
      check("w16_idle", int'(in_ready16), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
